addition_normalize_ctrl: RTL and testbench
==========================================

# addition_normalize_ctrl

Sequencing controller for the normalization stage (stage 4) of the single-precision adder. It accepts the mantissa sum from stage 3 and the bigger exponent from stage 1 over a valid/ready handshake, then finds the left-shift amount with an iterative leading-one scan, one bit per cycle. It drives stage 4's `normalize_position_in` and `valid_bit_in` and presents the result to stage 5 over a second valid/ready handshake. The scan is capped by the exponent, so the result never drops below exponent 0, and the block flags zero and underflow results.

## Interface
Parameters
- `MENT_WIDTH`, default 23, mantissa width (matches stage 4).
- `EXPO_WIDTH`, default 8, exponent width.

Ports (`PW` = `$clog2(MENT_WIDTH)+1`)
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `addition_in`  in  MENT_WIDTH  stage-3 mantissa sum.
- `bigger_exponent_in`  in  EXPO_WIDTH  stage-1 bigger exponent.
- `in_valid`  in  1  upstream operands valid.
- `in_ready`  out  1  controller can accept operands.
- `normalize_position_out`  out  PW  left-shift amount, to stage 4 `normalize_position_in`.
- `valid_bit_out`  out  1  to stage 4 `valid_bit_in`.
- `out_valid`  out  1  result valid to stage 5.
- `out_ready`  in  1  stage 5 accepts the result.
- `zero_out`  out  1  sum was all zeros.
- `underflow_out`  out  1  scan stopped at the exponent cap before reaching a leading one.

## Operation
- FSM states: IDLE, SCAN, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: capture `addition_in` into `shreg`, capture `bigger_exponent_in` into `exp_cap`, clear `count`, go to SCAN.
- SCAN, one evaluation per cycle, in this priority order:
  1. `shreg==0`: set `zero`, set `count`=0, go to DONE.
  2. `shreg[MENT_WIDTH-1]==1`: go to DONE.
  3. `count` (zero-extended) `== exp_cap`: set `underflow`, go to DONE.
  4. Otherwise: `shreg <= shreg<<1`, `count <= count+1`, stay in SCAN.
- `count` can never exceed `MENT_WIDTH-1`, because a nonzero `shreg` reaches bit MSB within that many shifts.
- DONE:
  - `out_valid`=1, `normalize_position_out`=`count`.
  - `zero_out` and `underflow_out` are held.
  - `valid_bit_out = out_valid & ~zero_out`, so stage 4 outputs zero for a zero sum.
  - On `out_valid && out_ready`: go to IDLE and clear the flags.
- `in_ready` is 0 in SCAN and DONE. There is no accept in the same cycle as handoff.
- Inputs are sampled only at accept. Changes to the inputs in later cycles have no effect.
- Output reset values:
  - `in_ready`=1 (it is IDLE decode).
  - `out_valid`=0, `valid_bit_out`=0, `normalize_position_out`=0, `zero_out`=0, `underflow_out`=0.
- All outputs are registered or decoded from registered state. No combinational path from any input to any output.

## Timing
- Accept in cycle 0. SCAN starts in cycle 1.
- With L = number of leading zeros, or the exponent cap if that is smaller: `out_valid` rises in cycle 2+L.
- A zero sum gives `out_valid` in cycle 2.
- Worst case: `out_valid` in cycle MENT_WIDTH+1 (cycle 24 at default width).
- Outputs stay stable while `out_valid && !out_ready`, for any number of stall cycles.
- After handoff in cycle N: `in_ready`=1 in cycle N+1; the next accept is possible in cycle N+1.
- Throughput: one operation per L+3 cycles at best.
- Reset asserted mid-SCAN or mid-DONE: all outputs go to reset values immediately (asynchronously), the FSM goes to IDLE, and the in-flight result is discarded. Release is synchronous to `clk`.
- `in_valid` held high through SCAN/DONE is ignored until IDLE.

## Test plan
- Defaults. `addition_in`=0x400000, exp=100 -> `out_valid` in cycle 2, position=0, `valid_bit_out`=1, both flags 0.
- `addition_in`=0x000001, exp=100 -> `out_valid` in cycle 24, position=22, no flags.
- `addition_in`=0x000100, exp=3 -> SCAN stops at `count`=3: `out_valid` in cycle 5, position=3, `underflow_out`=1.
- `addition_in`=0, exp=50 -> `out_valid` in cycle 2, `zero_out`=1, `valid_bit_out`=0, position=0.
- Back-pressure. `addition_in`=0x080000 (position 3), `out_ready` low for 5 cycles after `out_valid` -> outputs stable throughout, `in_ready`=0. Handoff on the 6th cycle, then `in_ready`=1 the next cycle. Toggling `in_valid` and the inputs mid-scan does not change the result.
- Reset. Assert `rst_n`=0 during SCAN at `count`=7 -> same-cycle `out_valid`=0, `in_ready`=1. After release, a fresh 0x200000 gives position 1 in cycle 3.

Source files
------------

// File: rtl/addition_normalize_ctrl.sv
// ---------------------------------------------------------------------------
// addition_normalize_ctrl
//
// Sequencing controller for the adder's normalization stage (stage 4).
// Accepts the stage-3 mantissa sum and the stage-1 bigger exponent over a
// valid/ready handshake. It then scans for the leading one, one bit per cycle.
// It presents the left-shift amount to stage 4 and to stage 5 over a second
// valid/ready handshake. The scan is capped by the exponent, so the
// normalized exponent never goes below zero.
//
// Ports
//   clk                     rising-edge clock
//   rst_n                   asynchronous active-low reset
//   addition_in             stage-3 mantissa sum            [MENT_WIDTH]
//   bigger_exponent_in      stage-1 bigger exponent         [EXPO_WIDTH]
//   in_valid / in_ready     operand handshake
//   normalize_position_out  left-shift amount to stage 4    [PW]
//   valid_bit_out           stage-4 valid (low for a zero sum)
//   out_valid / out_ready   result handshake to stage 5
//   zero_out                sum was all zeros
//   underflow_out           scan hit the exponent cap before a leading one
// ---------------------------------------------------------------------------
module addition_normalize_ctrl #(
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8,
    localparam int PW = $clog2(MENT_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MENT_WIDTH-1:0] addition_in,
    input  logic [EXPO_WIDTH-1:0] bigger_exponent_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [PW-1:0]         normalize_position_out,
    output logic                  valid_bit_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  zero_out,
    output logic                  underflow_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Common width for the count-vs-exponent compare, so both sides are
    // zero-extended whichever of the two is wider.
    localparam int CW = (PW > EXPO_WIDTH) ? PW : EXPO_WIDTH;

    logic [1:0]            state;
    logic [MENT_WIDTH-1:0] shreg;
    logic [EXPO_WIDTH-1:0] exp_cap;
    logic [PW-1:0]         count;
    logic                  zero_flag;
    logic                  underflow_flag;

    logic                  sh_zero;
    logic                  sh_msb;
    logic                  at_cap;
    logic                  accept;
    logic                  shift_en;

    assign sh_zero  = (shreg == '0);
    assign sh_msb   = shreg[MENT_WIDTH-1];
    assign at_cap   = (CW'(count) == CW'(exp_cap));
    assign accept   = in_valid && (state == S_IDLE);
    assign shift_en = (state == S_SCAN) && !sh_zero && !sh_msb && !at_cap;

    // Control: FSM, shift count and result flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            count          <= '0;
            zero_flag      <= 1'b0;
            underflow_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state          <= S_SCAN;
                        count          <= '0;
                        zero_flag      <= 1'b0;
                        underflow_flag <= 1'b0;
                    end
                end
                S_SCAN: begin
                    // A leading one found exactly at the cap is a normal
                    // result, so the MSB test outranks the cap test.
                    if (sh_zero) begin
                        zero_flag <= 1'b1;
                        count     <= '0;
                        state     <= S_DONE;
                    end else if (sh_msb) begin
                        state <= S_DONE;
                    end else if (at_cap) begin
                        underflow_flag <= 1'b1;
                        state          <= S_DONE;
                    end else begin
                        count <= count + PW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state          <= S_IDLE;
                        zero_flag      <= 1'b0;
                        underflow_flag <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Data: operand capture and scan shifter (no reset needed, only read in SCAN)
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg   <= addition_in;
            exp_cap <= bigger_exponent_in;
        end else if (shift_en) begin
            shreg <= shreg << 1;
        end
    end

    // Outputs decoded from registered state only
    assign in_ready               = (state == S_IDLE);
    assign out_valid              = (state == S_DONE);
    assign normalize_position_out = out_valid ? count : '0;
    assign zero_out               = zero_flag;
    assign underflow_out          = underflow_flag;
    assign valid_bit_out          = out_valid & ~zero_flag;

endmodule

// File: tb/tb_addition_normalize_ctrl.sv
module tb_addition_normalize_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [22:0] addition_in;
    logic [7:0]  bigger_exponent_in;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  normalize_position_out;
    logic        valid_bit_out;
    logic        out_valid;
    logic        out_ready;
    logic        zero_out;
    logic        underflow_out;

    addition_normalize_ctrl dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .addition_in            (addition_in),
        .bigger_exponent_in     (bigger_exponent_in),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .normalize_position_out (normalize_position_out),
        .valid_bit_out          (valid_bit_out),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .zero_out               (zero_out),
        .underflow_out          (underflow_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int lat;
        int pos;
        int z;
        int u;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: count leading zeros, cap by exponent, classify.
    function automatic exp_t model(input logic [22:0] a, input logic [7:0] e, input int acc);
        exp_t r;
        int   lz;
        lz = 23;
        for (int i = 0; i < 23; i++) if (a[i]) lz = 22 - i;
        r.acc = acc;
        if (a == 23'd0) begin
            r.z = 1; r.u = 0; r.pos = 0; r.lat = 2;
        end else if (int'(e) < lz) begin
            r.z = 0; r.u = 1; r.pos = int'(e); r.lat = 2 + int'(e);
        end else begin
            r.z = 0; r.u = 0; r.pos = lz; r.lat = 2 + lz;
        end
        return r;
    endfunction

    // Stimulus-side: every accepted operand pushes its expected result.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready)
            q.push_back(model(addition_in, bigger_exponent_in, cyc));
    end

    // Output monitor
    bit       rise_done  = 0;
    bit       ready_next = 0;
    bit       prev_v     = 0;
    bit       prev_r     = 0;
    int       prev_pos, prev_z, prev_u;

    always @(negedge clk) begin
        if (!rst_n) begin
            rise_done  = 0;
            ready_next = 0;
            prev_v     = 0;
        end else begin
            if (ready_next) begin
                chk("in_ready_after_handoff", int'(in_ready), 1);
                ready_next = 0;
            end
            if (out_valid) begin
                chk("in_ready_low_in_done", int'(in_ready), 0);
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    if (!rise_done) begin
                        chk("latency", cyc - q[0].acc, q[0].lat);
                        rise_done = 1;
                    end
                    if (prev_v && !prev_r) begin
                        chk("stall_pos_stable", int'(normalize_position_out), prev_pos);
                        chk("stall_zero_stable", int'(zero_out), prev_z);
                        chk("stall_uf_stable", int'(underflow_out), prev_u);
                    end
                    if (out_ready) begin
                        chk("position", int'(normalize_position_out), q[0].pos);
                        chk("zero_out", int'(zero_out), q[0].z);
                        chk("underflow_out", int'(underflow_out), q[0].u);
                        chk("valid_bit_out", int'(valid_bit_out), 1 - q[0].z);
                        void'(q.pop_front());
                        rise_done  = 0;
                        ready_next = 1;
                    end
                end
            end else begin
                if (prev_v && !prev_r) chk("out_valid_dropped_in_stall", 0, 1);
                chk("idle_valid_bit_low", int'(valid_bit_out), 0);
            end
            prev_v   = out_valid;
            prev_r   = out_ready;
            prev_pos = int'(normalize_position_out);
            prev_z   = int'(zero_out);
            prev_u   = int'(underflow_out);
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after handoff.
    task automatic do_op(input logic [22:0] a, input logic [7:0] e,
                         input int stall, input bit wiggle);
        int n;
        addition_in        = a;
        bigger_exponent_in = e;
        in_valid           = 1'b1;
        out_ready          = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 60) begin
            if (wiggle) begin
                in_valid           = 1'($urandom_range(0, 1));
                addition_in        = 23'($urandom);
                bigger_exponent_in = 8'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        if (n >= 60) chk("timeout_out_valid", 0, 1);
        for (int i = 0; i < stall; i++) begin
            if (wiggle) begin
                in_valid    = 1'($urandom_range(0, 1));
                addition_in = 23'($urandom);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic start_op(input logic [22:0] a, input logic [7:0] e);
        addition_in        = a;
        bigger_exponent_in = e;
        in_valid           = 1'b1;
        out_ready          = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_valid_bit", int'(valid_bit_out), 0);
        chk("rst_position", int'(normalize_position_out), 0);
        chk("rst_zero", int'(zero_out), 0);
        chk("rst_underflow", int'(underflow_out), 0);
        q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [22:0] a;
        logic [7:0]  e;
        rst_n              = 1'b0;
        in_valid           = 1'b0;
        out_ready          = 1'b0;
        addition_in        = '0;
        bigger_exponent_in = '0;
        #2;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_position", int'(normalize_position_out), 0);
        chk("reset_flags", int'({zero_out, underflow_out, valid_bit_out}), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        do_op(23'h400000, 8'd100, 0, 0);
        do_op(23'h000001, 8'd100, 0, 0);
        do_op(23'h000100, 8'd3,   0, 0);
        do_op(23'h000000, 8'd50,  0, 0);
        do_op(23'h080000, 8'd100, 5, 1);
        do_op(23'h000001, 8'd22,  1, 0);
        do_op(23'h000002, 8'd0,   0, 0);
        do_op(23'h400000, 8'd0,   2, 0);

        // Reset mid-SCAN at count 7
        start_op(23'h000100, 8'd100);
        repeat (7) @(posedge clk);
        #2;
        reset_pulse();
        do_op(23'h200000, 8'd100, 0, 0);

        // Reset while holding a result in DONE
        start_op(23'h000000, 8'd9);
        n = 0;
        while (!out_valid && n < 60) begin @(posedge clk); #1; n++; end
        if (n >= 60) chk("timeout_done_for_reset", 0, 1);
        @(posedge clk); #2;
        reset_pulse();
        do_op(23'h010000, 8'd100, 0, 0);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) a = '0;
            else a = 23'($urandom) >> $urandom_range(0, 22);
            if ($urandom_range(0, 2) == 0) e = 8'($urandom_range(0, 25));
            else e = 8'($urandom);
            do_op(a, e, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        n = 0;
        while (q.size() != 0 && n < 50) begin @(posedge clk); n++; end
        chk("scoreboard_drained", q.size(), 0);
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
